// File: rtl/bresen_stream_pkg.sv
// bresen_stream_pkg: shared types for the Bresenham line blocks.
//   state_t   : segment FSM states (IDLE, SETUP, RUN)
//   point2d_t : default COORD_W=16 point, kept as the legacy Point2D shape
//   make_point: builds a point2d_t from two signed coordinates
package bresen_stream_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, RUN} state_t;

    localparam int POINT_W = 16;

    typedef struct packed {
        logic signed [POINT_W-1:0] x;
        logic signed [POINT_W-1:0] y;
    } point2d_t;

    function automatic point2d_t make_point(input logic signed [POINT_W-1:0] x,
                                            input logic signed [POINT_W-1:0] y);
        point2d_t p;
        p.x = x;
        p.y = y;
        return p;
    endfunction

endpackage

// File: rtl/bresen_step.sv
// bresen_step: one combinational Bresenham step on a W-bit signed state.
//   x_i, y_i, err_i : current position and error term
//   dx_i, dy_i      : |dx| and -|dy|
//   sx_i, sy_i      : step directions (+1/-1)
//   x_o, y_o, err_o : position and error after one step
module bresen_step
    import bresen_stream_pkg::*;
#(
    parameter int W = 18
) (
    input  logic signed [W-1:0] x_i,
    input  logic signed [W-1:0] y_i,
    input  logic signed [W-1:0] err_i,
    input  logic signed [W-1:0] dx_i,
    input  logic signed [W-1:0] dy_i,
    input  logic signed [W-1:0] sx_i,
    input  logic signed [W-1:0] sy_i,
    output logic signed [W-1:0] x_o,
    output logic signed [W-1:0] y_o,
    output logic signed [W-1:0] err_o
);

    localparam logic signed [W-1:0] ZERO = '0;

    // 2*err is kept one bit wider so the doubling can never wrap.
    logic signed [W:0] e2, dx_e, dy_e;
    logic              step_x, step_y;

    assign e2     = {err_i, 1'b0};
    assign dx_e   = {dx_i[W-1], dx_i};
    assign dy_e   = {dy_i[W-1], dy_i};
    assign step_x = e2 >= dy_e;
    assign step_y = e2 <= dx_e;
    assign x_o    = step_x ? x_i + sx_i : x_i;
    assign y_o    = step_y ? y_i + sy_i : y_i;
    assign err_o  = err_i + (step_x ? dy_i : ZERO) + (step_y ? dx_i : ZERO);

endmodule

// File: rtl/bresen_stream.sv
// bresen_stream: streaming Bresenham rasteriser, one segment in, one pixel per cycle out.
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready, p_*, q_*   : segment request handshake, endpoints P and Q
//   abort                         : cancel the current segment (no done pulse)
//   out_valid/out_ready, out_x/y  : pixel stream with backpressure
//   out_first, out_last           : first emitted pixel / pixel equal to Q
//   busy, done                    : segment in progress / completion pulse
// Optional: define BRESEN_CLIP_EN to drop pixels outside a CLIP_W x CLIP_H viewport.
module bresen_stream
    import bresen_stream_pkg::*;
#(
    parameter int COORD_W = 16,
    parameter int CLIP_W  = 640,
    parameter int CLIP_H  = 480
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [COORD_W-1:0] p_x,
    input  logic signed [COORD_W-1:0] p_y,
    input  logic signed [COORD_W-1:0] q_x,
    input  logic signed [COORD_W-1:0] q_y,
    input  logic                      abort,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [COORD_W-1:0] out_x,
    output logic signed [COORD_W-1:0] out_y,
    output logic                      out_first,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

    localparam int W = COORD_W + 2;
    localparam logic signed [W-1:0] ZERO = '0;
    localparam logic signed [W-1:0] POS1 = W'(1);
    localparam logic signed [W-1:0] NEG1 = -W'(1);

    state_t                    state_q, state_d;
    logic signed [COORD_W-1:0] px_q, px_d, py_q, py_d, qx_q, qx_d, qy_q, qy_d;
    logic signed [W-1:0]       x_q, x_d, y_q, y_d, err_q, err_d;
    logic signed [W-1:0]       dx_q, dx_d, dy_q, dy_d, sx_q, sx_d, sy_q, sy_d;
    logic                      first_q, first_d, done_q, done_d;

    logic signed [W-1:0] ddx, ddy, nx, ny, nerr;
    logic                at_q, visible, adv;

    assign ddx  = W'(qx_q) - W'(px_q);
    assign ddy  = W'(qy_q) - W'(py_q);
    assign at_q = (x_q == W'(qx_q)) && (y_q == W'(qy_q));

`ifdef BRESEN_CLIP_EN
    localparam logic signed [W-1:0] VIEW_W = W'(CLIP_W);
    localparam logic signed [W-1:0] VIEW_H = W'(CLIP_H);
    assign visible = (x_q >= ZERO) && (x_q < VIEW_W) && (y_q >= ZERO) && (y_q < VIEW_H);
`else
    // Viewport is ignored in this build: every pixel is visible.
    assign visible = 1'b1 | (CLIP_W == 0) | (CLIP_H == 0);
`endif

    // Hidden pixels advance on their own; visible ones wait for the consumer.
    assign adv = (state_q == RUN) && (!visible || out_ready);

    bresen_step #(.W(W)) u_step (
        .x_i  (x_q),
        .y_i  (y_q),
        .err_i(err_q),
        .dx_i (dx_q),
        .dy_i (dy_q),
        .sx_i (sx_q),
        .sy_i (sy_q),
        .x_o  (nx),
        .y_o  (ny),
        .err_o(nerr)
    );

    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        qx_d    = qx_q;
        qy_d    = qy_q;
        x_d     = x_q;
        y_d     = y_q;
        err_d   = err_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        first_d = first_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    px_d    = p_x;
                    py_d    = p_y;
                    qx_d    = q_x;
                    qy_d    = q_y;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                dx_d    = ddx < ZERO ? -ddx : ddx;
                dy_d    = ddy < ZERO ? ddy : -ddy;
                sx_d    = ddx < ZERO ? NEG1 : POS1;
                sy_d    = ddy < ZERO ? NEG1 : POS1;
                err_d   = (ddx < ZERO ? -ddx : ddx) + (ddy < ZERO ? ddy : -ddy);
                x_d     = W'(px_q);
                y_d     = W'(py_q);
                first_d = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (adv) begin
                    first_d = visible ? 1'b0 : first_q;
                    if (at_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        x_d   = nx;
                        y_d   = ny;
                        err_d = nerr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            px_q    <= '0;
            py_q    <= '0;
            qx_q    <= '0;
            qy_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            err_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            qx_q    <= qx_d;
            qy_q    <= qy_d;
            x_q     <= x_d;
            y_q     <= y_d;
            err_q   <= err_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            first_q <= first_d;
            done_q  <= done_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign out_valid = (state_q == RUN) && visible;
    assign out_x     = x_q[COORD_W-1:0];
    assign out_y     = y_q[COORD_W-1:0];
    assign out_first = out_valid && first_q;
    assign out_last  = out_valid && at_q;
    assign done      = done_q;

endmodule

// File: tb/tb_bresen_stream.sv
// tb_bresen_stream: directed self-checking bench for bresen_stream.
module tb_bresen_stream;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               abort = 1'b0;
    logic               out_ready = 1'b1;
    logic signed [15:0] p_x = '0, p_y = '0, q_x = '0, q_y = '0;
    logic               in_ready, out_valid, out_first, out_last, busy, done;
    logic signed [15:0] out_x, out_y;

    int checks = 0;
    int errors = 0;
    int ex[$];
    int ey[$];
    int cur_qx, cur_qy, cyc;

    bresen_stream #(.COORD_W(16), .CLIP_W(8), .CLIP_H(480)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .p_x      (p_x),
        .p_y      (p_y),
        .q_x      (q_x),
        .q_y      (q_y),
        .abort    (abort),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_first(out_first),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_seg(input int px, input int py, input int qx, input int qy);
        @(negedge clk);
        p_x = 16'(px);
        p_y = 16'(py);
        q_x = 16'(qx);
        q_y = 16'(qy);
        cur_qx = qx;
        cur_qy = qy;
        in_valid = 1'b1;
        check("in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("setup_valid", out_valid, 0);
        check("setup_busy", busy, 1);
    endtask

    task automatic collect(input int n, input bit tog, output int cycles);
        int  k = 0;
        int  hx = 0;
        int  hy = 0;
        int  t = 0;
        bit  stalled = 1'b0;
        cycles = 0;
        while (k < n && cycles < 200) begin
            @(negedge clk);
            cycles++;
            out_ready = tog ? (t % 3 == 0) : 1'b1;
            t++;
            if (out_valid) begin
                if (stalled) begin
                    check("hold_x", out_x, hx);
                    check("hold_y", out_y, hy);
                end
                if (out_ready) begin
                    check("pix_x", out_x, ex[k]);
                    check("pix_y", out_y, ey[k]);
                    check("pix_first", out_first, int'(k == 0));
                    check("pix_last", out_last, int'(ex[k] == cur_qx && ey[k] == cur_qy));
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hx = out_x;
                    hy = out_y;
                end
            end
        end
        check("pix_count", k, n);
    endtask

    task automatic finish_seg();
        @(negedge clk);
        out_ready = 1'b1;
        check("done_pulse", done, 1);
        check("idle_ready", in_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_valid", out_valid, 0);
        @(negedge clk);
        check("done_clear", done, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_x", out_x, 0);
        check("rst_y", out_y, 0);

        ex = '{0, 1, 2, 3, 4, 5};
        ey = '{0, 0, 1, 1, 2, 2};
        start_seg(0, 0, 5, 2);
        collect(6, 1'b0, cyc);
        check("shallow_cycles", cyc, 6);
        finish_seg();

        ex = '{3};
        ey = '{3};
        start_seg(3, 3, 3, 3);
        collect(1, 1'b0, cyc);
        finish_seg();

        ex = '{4, 3, 2, 1, 0};
        ey = '{-1, -2, -3, -4, -5};
        start_seg(4, -1, 0, -5);
        collect(5, 1'b1, cyc);
        finish_seg();

        ex = '{0, 1, 2};
        ey = '{0, 0, 0};
        start_seg(0, 0, 10, 0);
        collect(3, 1'b0, cyc);
        @(negedge clk);
        check("abort_pre_valid", out_valid, 1);
        check("abort_pre_x", out_x, 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", in_ready, 1);
        check("abort_done", done, 0);
        @(negedge clk);
        check("abort_done_late", done, 0);

        ex = '{0, 1, 2};
        ey = '{0, 1, 2};
        start_seg(0, 0, 2, 2);
        collect(3, 1'b0, cyc);
        finish_seg();

        ex = '{0, 0};
        ey = '{0, 1};
        start_seg(0, 0, 0, 9);
        collect(2, 1'b0, cyc);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_valid", out_valid, 0);
        check("mrst_x", out_x, 0);
        check("mrst_y", out_y, 0);
        check("mrst_first", out_first, 0);
        check("mrst_last", out_last, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_ready", in_ready, 1);

        ex = '{-2, -1, 0, 1};
        ey = '{1, 1, 0, 0};
        start_seg(-2, 1, 1, 0);
        collect(4, 1'b0, cyc);
        finish_seg();

`ifdef BRESEN_CLIP_EN
        begin
            int w = 0;
            bit seen = 1'b0;
            ex = '{6, 7};
            ey = '{0, 0};
            start_seg(6, 0, 10, 0);
            collect(2, 1'b0, cyc);
            while (!seen && w < 10) begin
                @(negedge clk);
                w++;
                if (out_valid) check("clip_hidden_valid", out_valid, 0);
                seen = done;
            end
            check("clip_done", seen, 1);
            check("clip_steps", w, 4);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
